// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks and appends 0x80, zero fill and the 64-bit bit length.
// One block in flight; in_ready drops while a block is held and there is no skid buffer.
module sha256_padder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [63:0]       bcnt_q, bcnt_d;
  logic [0:15][31:0] buf_q, buf_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              ovf_pad_q, ovf_pad_d;
  logic              first_q, first_d;

  logic [2:0]        nbytes;
  logic [6:0]        pos;
  logic [63:0]       total;
  logic [63:0]       len_bits;
  logic [63:0]       extra_len_bits;
  logic [31:0]       last_word;

  assign nbytes         = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign pos            = {1'b0, wcnt_q, 2'b00} + {4'b0000, nbytes};
  assign total          = bcnt_q + {61'd0, nbytes};
  assign len_bits       = {total[60:0], 3'b000};
  assign extra_len_bits = {bcnt_q[60:0], 3'b000};

  // Keep the valid bytes, place the 0x80 marker right after them, clear the rest.
  always_comb begin
    last_word = 32'h8000_0000;
    case (nbytes)
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      3'd4:    last_word = in_data;
      default: last_word = 32'h8000_0000;
    endcase
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q != FILL);
  assign blk_data  = buf_q;
  assign blk_first = blk_valid & first_q;
  assign blk_last  = blk_valid & last_q;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    buf_d     = buf_q;
    last_d    = last_q;
    ovf_d     = ovf_q;
    ovf_pad_d = ovf_pad_q;
    first_d   = first_q;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (!in_last) begin
            buf_d[wcnt_q] = in_data;
            bcnt_d        = bcnt_q + 64'd4;
            wcnt_d        = wcnt_q + 4'd1;
            if (wcnt_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
              ovf_d   = 1'b0;
            end
          end else begin
            bcnt_d = total;
            for (int i = 0; i < 16; i++) begin
              if (i > int'(wcnt_q)) buf_d[i] = 32'h0;
            end
            buf_d[wcnt_q] = last_word;
            // A full last word pushes the marker into the next word, if one is left.
            if (nbytes == 3'd4 && wcnt_q != 4'd15) buf_d[wcnt_q + 4'd1] = 32'h8000_0000;
            if (pos <= 7'd55) begin
              buf_d[14] = len_bits[63:32];
              buf_d[15] = len_bits[31:0];
              last_d    = 1'b1;
              ovf_d     = 1'b0;
            end else begin
              last_d    = 1'b0;
              ovf_d     = 1'b1;
              ovf_pad_d = (pos == 7'd64);
            end
            wcnt_d  = 4'd0;
            state_d = EMIT;
          end
        end
      end

      EMIT: begin
        if (blk_ready) begin
          first_d = 1'b0;
          if (last_q) begin
            state_d = FILL;
            wcnt_d  = 4'd0;
            bcnt_d  = 64'd0;
            buf_d   = '0;
            last_d  = 1'b0;
            first_d = 1'b1;
          end else if (ovf_q) begin
            buf_d     = '0;
            buf_d[0]  = ovf_pad_q ? 32'h8000_0000 : 32'h0;
            buf_d[14] = extra_len_bits[63:32];
            buf_d[15] = extra_len_bits[31:0];
            last_d    = 1'b1;
            ovf_d     = 1'b0;
            ovf_pad_d = 1'b0;
            state_d   = EXTRA;
          end else begin
            state_d = FILL;
          end
        end
      end

      EXTRA: begin
        if (blk_ready) begin
          state_d = FILL;
          wcnt_d  = 4'd0;
          bcnt_d  = 64'd0;
          buf_d   = '0;
          last_d  = 1'b0;
          first_d = 1'b1;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      wcnt_q    <= 4'd0;
      bcnt_q    <= 64'd0;
      buf_q     <= '0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_pad_q <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      buf_q     <= buf_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      ovf_pad_q <= ovf_pad_d;
      first_q   <= first_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known messages with hand-computed padded blocks.
module tb_sha256_padder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  int checks = 0;
  int errors = 0;

  sha256_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge after the word is taken.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_word: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] d, output logic f, output logic l);
    int t;
    t = 0;
    blk_ready = 1'b1;
    while (!blk_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL get_block: blk_valid stayed 0 for %0d cycles, required 1", t);
    end
    d = blk_data;
    f = blk_first;
    l = blk_last;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    in_bytes  = 3'd0;
    blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got %b need 0", blk_valid); end
    checks++;
    if (blk_first !== 1'b0 || blk_last !== 1'b0) begin
      errors++; $display("FAIL reset_first_last got %b%b need 00", blk_first, blk_last);
    end
    checks++;
    if (blk_data !== 512'd0) begin errors++; $display("FAIL reset_blk_data got %h need 0", blk_data); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b need 0", blk_valid); end
  endtask

  task automatic test_abc;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $display("FAIL abc_latency blk_valid got %b need 1", blk_valid); end
    get_block(d, f, l);
    e = '0;
    e[0]  = 32'h6162_6380;
    e[15] = 32'h0000_0018;
    checks++;
    if ({d, f, l} !== {e, 2'b11}) begin
      errors++; $display("FAIL abc got %h f%b l%b need %h f1 l1", d, f, l, e);
    end
  endtask

  task automatic test_empty;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    get_block(d, f, l);
    e = '0;
    e[0] = 32'h8000_0000;
    checks++;
    if ({d, f, l} !== {e, 2'b11}) begin
      errors++; $display("FAIL empty got %h f%b l%b need %h f1 l1", d, f, l, e);
    end
  endtask

  // 55 bytes: marker lands at byte 55, the last position that still fits the length.
  task automatic test_55_bytes;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    e = '0;
    for (int i = 0; i < 13; i++) begin
      send_word(32'h5500_0000 | i, 1'b0, 3'd0);
      e[i] = 32'h5500_0000 | i;
    end
    send_word(32'hAABB_CCDD, 1'b1, 3'd3);
    e[13] = 32'hAABB_CC80;
    e[15] = 32'h0000_01B8;
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b11}) begin
      errors++; $display("FAIL len55 got %h f%b l%b need %h f1 l1", d, f, l, e);
    end
  endtask

  task automatic test_56_bytes;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    e = '0;
    for (int i = 0; i < 13; i++) begin
      send_word(32'hA000_0000 | i, 1'b0, 3'd0);
      e[i] = 32'hA000_0000 | i;
    end
    send_word(32'hA000_000D, 1'b1, 3'd4);
    e[13] = 32'hA000_000D;
    e[14] = 32'h8000_0000;
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b10}) begin
      errors++; $display("FAIL len56_blk1 got %h f%b l%b need %h f1 l0", d, f, l, e);
    end
    e = '0;
    e[15] = 32'h0000_01C0;
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b01}) begin
      errors++; $display("FAIL len56_blk2 got %h f%b l%b need %h f0 l1", d, f, l, e);
    end
  endtask

  // 60 bytes sent as 15 full words plus an empty last word at index 15.
  task automatic test_60_bytes;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    e = '0;
    for (int i = 0; i < 15; i++) begin
      send_word(32'h6000_0000 | i, 1'b0, 3'd0);
      e[i] = 32'h6000_0000 | i;
    end
    send_word(32'h1234_5678, 1'b1, 3'd0);
    e[15] = 32'h8000_0000;
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b10}) begin
      errors++; $display("FAIL len60_blk1 got %h f%b l%b need %h f1 l0", d, f, l, e);
    end
    e = '0;
    e[15] = 32'h0000_01E0;
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b01}) begin
      errors++; $display("FAIL len60_blk2 got %h f%b l%b need %h f0 l1", d, f, l, e);
    end
  endtask

  // 64 bytes with idle gaps between words; content must not depend on the gaps.
  task automatic test_64_bytes_gaps;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'hC0DE_0000 | i, (i == 15), 3'd4);
      e[i] = 32'hC0DE_0000 | i;
      repeat (i % 3) @(negedge clk);
    end
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b10}) begin
      errors++; $display("FAIL len64_blk1 got %h f%b l%b need %h f1 l0", d, f, l, e);
    end
    e = '0;
    e[0]  = 32'h8000_0000;
    e[15] = 32'h0000_0200;
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b01}) begin
      errors++; $display("FAIL len64_blk2 got %h f%b l%b need %h f0 l1", d, f, l, e);
    end
  endtask

  // in_bytes above 4 counts as a full word.
  task automatic test_bytes_clamp;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    send_word(32'h6162_6364, 1'b1, 3'd7);
    get_block(d, f, l);
    e = '0;
    e[0]  = 32'h6162_6364;
    e[1]  = 32'h8000_0000;
    e[15] = 32'h0000_0020;
    checks++;
    if ({d, f, l} !== {e, 2'b11}) begin
      errors++; $display("FAIL clamp got %h f%b l%b need %h f1 l1", d, f, l, e);
    end
  endtask

  task automatic test_backpressure;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    e = '0;
    e[0]  = 32'h6162_6380;
    e[15] = 32'h0000_0018;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    in_valid = 1'b1;
    in_data  = 32'h6465_6600;
    in_last  = 1'b1;
    in_bytes = 3'd3;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b need 1", c, blk_valid); end
      checks++;
      if (blk_data !== e) begin errors++; $display("FAIL bp_stable cycle %0d got %h need %h", c, blk_data, e); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b need 0", c, in_ready); end
      @(negedge clk);
    end
    // Handshake edge also sees in_valid=1; the word must wait for the next edge.
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got in_ready %b blk_valid %b need 1 0", in_ready, blk_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    e[0] = 32'h6465_6680;
    get_block(d, f, l);
    checks++;
    if ({d, f, l} !== {e, 2'b11}) begin
      errors++; $display("FAIL bp_held_word got %h f%b l%b need %h f1 l1", d, f, l, e);
    end
    checks++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_no_dup got blk_valid %b in_ready %b need 0 1", blk_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_message;
    logic [0:15][31:0] e;
    logic [511:0] d;
    logic f, l;
    for (int i = 0; i < 7; i++) send_word(32'hBAD0_0000 | i, 1'b0, 3'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_outputs got blk_valid %b in_ready %b need 0 1", blk_valid, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_block(d, f, l);
    e = '0;
    e[0]  = 32'h6162_6380;
    e[15] = 32'h0000_0018;
    checks++;
    if ({d, f, l} !== {e, 2'b11}) begin
      errors++; $display("FAIL rst_mid_abc got %h f%b l%b need %h f1 l1", d, f, l, e);
    end
  endtask

  initial begin
    test_reset;
    test_abc;
    test_empty;
    test_55_bytes;
    test_56_bytes;
    test_60_bytes;
    test_64_bytes_gaps;
    test_bytes_clamp;
    test_backpressure;
    test_reset_mid_message;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
